// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI responder and its sub-module.
// Contents:
//   - state encodings ST_IDLE / ST_ADDR / ST_DATA / ST_DONE
//   - frame header bit positions RW_BIT / MB_BIT
//   - default address and data widths
package spi_responder_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    // Header byte layout: {rw, mb, addr[5:0]}
    localparam int RW_BIT = 7;
    localparam int MB_BIT = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/spi_responder_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, plus single-cycle
// rise/fall pulses derived from the synchronized level.
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   din       asynchronous input
//   level     synchronized level (SYNC_STAGES clk cycles of latency)
//   rise      1-cycle pulse after level goes 0 -> 1
//   fall      1-cycle pulse after level goes 1 -> 0
// RESET_VAL is the idle level of the input, so no false edge is seen
// coming out of reset. SYNC_STAGES must be at least 2.
module spi_responder_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {SYNC_STAGES{RESET_VAL}};
            prev_reg <= RESET_VAL;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-3 (CPOL=1, CPHA=1), MSB-first register target with a 64x8
// register file. Frame: header byte {rw, mb, addr[5:0]} then data byte(s);
// rw=1 read, rw=0 write. All SPI pins are oversampled in the clk domain.
// Frames are byte-oriented: the bit counter assumes DATA_W = 8.
// Ports:
//   clk, rst                     system clock, asynchronous active-high reset
//   spi_clk, spi_cs, spi_mosi    SPI inputs (spi_clk idles high, spi_cs active-low)
//   spi_miso                     SPI read data, 0 outside the data phase of a read
//   loc_we, loc_addr, loc_wdata  local (sensor model) register write port
//   wr_strobe, wr_addr, wr_data  1-cycle notification of a committed SPI write
//   busy                         synchronized chip select is active
// Optional feature: define SPI_BURST_EN to let mb=1 frames continue over
// several data bytes with an auto-incrementing (wrapping) address.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [DATA_W-1:0] ID_VALUE    = 8'hE5,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [DATA_W-1:0] loc_wdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic sck_level_unused, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck_sync (
        .clk(clk), .rst(rst), .din(spi_clk),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .din(spi_cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(spi_mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    logic [1:0]        state_reg;
    logic [2:0]        bit_cnt_reg;
    logic [DATA_W-2:0] shift_in_reg;   // bits already received of the current byte
    logic [DATA_W-1:0] rd_shift_reg;
    logic              rw_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] regs_reg [0:NUM_REGS-1];

    // Byte as it stands once the current mosi bit is included.
    logic [DATA_W-1:0] byte_in;
    logic [ADDR_W-1:0] addr_next;
    logic              spi_we;
    logic              burst_cont;
    logic              byte_done;

    assign byte_in   = {shift_in_reg, mosi_level};
    assign addr_next = addr_reg + ADDR_W'(1);
    assign byte_done = sck_rise && (bit_cnt_reg == 3'd7);

    // CS edges take priority over clock edges in the FSM, so a commit is
    // only possible when no CS edge is pending in the same cycle.
    assign spi_we = (state_reg == ST_DATA) && !cs_rise && !cs_fall && byte_done && !rw_reg;

`ifdef SPI_BURST_EN
    logic mb_reg;
    assign burst_cont = mb_reg;
`else
    // Without burst support the mb header bit has no effect and is dropped.
    assign burst_cont = 1'b0;
`endif

    // Per-register write decode; the SPI commit outranks a local write.
    logic [NUM_REGS-1:0] spi_hit;
    logic [NUM_REGS-1:0] loc_hit;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
        assign spi_hit[gi] = spi_we && (addr_reg == ADDR_W'(gi));
        assign loc_hit[gi] = loc_we && (loc_addr == ADDR_W'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= (i == 0) ? ID_VALUE : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (spi_hit[i]) begin
                    regs_reg[i] <= byte_in;
                end else if (loc_hit[i]) begin
                    regs_reg[i] <= loc_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            shift_in_reg <= '0;
            rd_shift_reg <= '0;
            rw_reg       <= 1'b0;
            addr_reg     <= '0;
            spi_miso     <= 1'b0;
            wr_strobe    <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
`ifdef SPI_BURST_EN
            mb_reg       <= 1'b0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            if (cs_rise) begin
                // Frame ends wherever it is; any partial byte is dropped.
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= '0;
                spi_miso    <= 1'b0;
            end else if (cs_fall) begin
                state_reg   <= ST_ADDR;
                bit_cnt_reg <= '0;
                spi_miso    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_ADDR: begin
                        if (sck_rise) begin
                            shift_in_reg <= byte_in[DATA_W-2:0];
                            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                            if (byte_done) begin
                                rw_reg       <= byte_in[RW_BIT];
                                addr_reg     <= byte_in[ADDR_W-1:0];
                                // Read value is frozen here; later local
                                // writes do not affect the byte in flight.
                                rd_shift_reg <= regs_reg[byte_in[ADDR_W-1:0]];
                                state_reg    <= ST_DATA;
`ifdef SPI_BURST_EN
                                mb_reg       <= byte_in[MB_BIT];
`endif
                            end
                        end
                    end
                    ST_DATA: begin
                        // Mode 3: drive on the falling edge so the initiator
                        // samples a stable bit on the following rise.
                        if (sck_fall && rw_reg) begin
                            spi_miso     <= rd_shift_reg[DATA_W-1];
                            rd_shift_reg <= {rd_shift_reg[DATA_W-2:0], 1'b0};
                        end
                        if (sck_rise) begin
                            shift_in_reg <= byte_in[DATA_W-2:0];
                            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                            if (spi_we) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr_reg;
                                wr_data   <= byte_in;
                            end
                            if (byte_done) begin
                                if (burst_cont) begin
                                    addr_reg     <= addr_next;
                                    rd_shift_reg <= regs_reg[addr_next];
                                end else begin
                                    state_reg <= ST_DONE;
                                    spi_miso  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        // IDLE and DONE: SPI clock edges are ignored.
                        spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = ~cs_level;

endmodule

// File: tb/tb_spi_responder.sv
module tb_spi_responder;

    localparam int HALF = 6;   // clk cycles per spi_clk phase
`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk = 1'b1;
    logic       spi_cs = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       loc_we = 1'b0;
    logic [5:0] loc_addr = '0;
    logic [7:0] loc_wdata = '0;
    logic       wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [64];      // reference register file
    txn_t exp_wr_q[$];
    txn_t exp_rd_q[$];

    // Extras applied inside the next frame.
    bit         mid_loc_en = 1'b0;
    logic [5:0] mid_loc_addr = '0;
    logic [7:0] mid_loc_data = '0;
    bit         col_en = 1'b0;
    logic [5:0] col_addr = '0;
    logic [7:0] col_data = '0;

    spi_responder dut (
        .clk(clk), .rst(rst),
        .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Write monitor: every committed SPI write must match the oldest expected one.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            if (!rst && wr_strobe) begin
                if (exp_wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got addr=%0h data=%0h, no write expected", wr_addr, wr_data);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e.a));
                    check("wr_data", 32'(wr_data), 32'(e.d));
                end
            end
        end
    end

    // Read monitor: samples the bus like the initiator (on SCK rise) and checks
    // every complete 16-bit read frame at CS release.
    initial begin
        logic [15:0] mon_mosi = '0;
        logic [15:0] mon_miso = '0;
        int          mon_cnt = 0;
        txn_t        e;
        forever begin
            @(posedge spi_clk or posedge spi_cs);
            if (spi_cs) begin
                if (mon_cnt == 16 && mon_mosi[15]) begin
                    if (exp_rd_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rd_unexpected: got data=%0h, no read expected", mon_miso[7:0]);
                    end else begin
                        e = exp_rd_q.pop_front();
                        check("rd_data", 32'(mon_miso[7:0]), 32'(e.d));
                        check("rd_hdr_miso", 32'(mon_miso[15:8]), 32'h0);
                    end
                end
                mon_cnt = 0;
            end else begin
                mon_mosi = {mon_mosi[14:0], spi_mosi};
                mon_miso = {mon_miso[14:0], spi_miso};
                mon_cnt++;
            end
        end
    end

    task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_we = 1'b1;
        loc_addr = a;
        loc_wdata = d;
        @(negedge clk);
        loc_we = 1'b0;
        mem[a] = d;
        $display("txn loc  addr=%02h data=%02h", a, d);
    endtask

    // One mode-3 frame of nbits bits: header, d0, d1 (MSB first).
    task automatic spi_frame(input logic [7:0] hdr, input logic [7:0] d0,
                             input logic [7:0] d1, input int nbits);
        logic [23:0] sh;
        logic [5:0]  wa;
        txn_t        t;
        bit          seen;
        sh = {hdr, d0, d1};
        // Reference model: a colliding local write lands first, the SPI write wins.
        if (col_en) mem[col_addr] = col_data;
        if (nbits >= 16) begin
            if (hdr[7]) begin
                t.a = hdr[5:0];
                t.d = mem[hdr[5:0]];
                exp_rd_q.push_back(t);
            end else begin
                for (int k = 0; k < (nbits - 8) / 8; k++) begin
                    if (k == 0 || (BURST && hdr[6])) begin
                        wa = hdr[5:0] + 6'(k);
                        mem[wa] = sh[15 - 8 * k -: 8];
                        t.a = wa;
                        t.d = mem[wa];
                        exp_wr_q.push_back(t);
                    end
                end
            end
        end
        $display("txn spi  hdr=%02h d0=%02h d1=%02h bits=%0d", hdr, d0, d1, nbits);

        @(negedge clk);
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        check("busy_in_frame", 32'(busy), 32'h1);
        for (int i = 0; i < nbits; i++) begin
            spi_clk = 1'b0;
            spi_mosi = sh[23 - i];
            if (mid_loc_en && i == 12) begin
                loc_we = 1'b1;
                loc_addr = mid_loc_addr;
                loc_wdata = mid_loc_data;
                @(negedge clk);
                loc_we = 1'b0;
                mem[mid_loc_addr] = mid_loc_data;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            spi_clk = 1'b1;
            if (col_en && i == 15) begin
                // Hold loc_we up to and including the commit cycle only.
                loc_we = 1'b1;
                loc_addr = col_addr;
                loc_wdata = col_data;
                seen = 1'b0;
                for (int w = 0; w < 20 && !seen; w++) begin
                    @(posedge clk);
                    #1;
                    seen = wr_strobe;
                end
                loc_we = 1'b0;
                check("collide_commit_seen", 32'(seen), 32'h1);
                @(negedge clk);
            end
            repeat (HALF) @(negedge clk);
        end
        spi_cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("busy_after_frame", 32'(busy), 32'h0);
        mid_loc_en = 1'b0;
        col_en = 1'b0;
    endtask

    initial begin
        int         op;
        logic [5:0] a;
        logic [7:0] d;
        logic       mbr;

        for (int i = 0; i < 64; i++) mem[i] = (i == 0) ? 8'hE5 : 8'h00;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 32'h0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Device ID after reset.
        spi_frame(8'h80, 8'h00, 8'h00, 16);
        // Write then read back.
        spi_frame(8'h12, 8'h5A, 8'h00, 16);
        spi_frame(8'h92, 8'h00, 8'h00, 16);
        // Local write visible to SPI; a local write during the data byte
        // does not disturb the byte in flight.
        loc_write(6'h20, 8'h3C);
        spi_frame(8'hA0, 8'h00, 8'h00, 16);
        mid_loc_en = 1'b1;
        mid_loc_addr = 6'h20;
        mid_loc_data = 8'h77;
        spi_frame(8'hA0, 8'h00, 8'h00, 16);
        spi_frame(8'hA0, 8'h00, 8'h00, 16);
        // Aborted write after 4 data bits, then a normal frame.
        spi_frame(8'h05, 8'hFF, 8'h00, 12);
        spi_frame(8'h85, 8'h00, 8'h00, 16);
        // Same-cycle SPI commit and local write: same address, then different.
        col_en = 1'b1;
        col_addr = 6'h30;
        col_data = 8'h99;
        spi_frame(8'h30, 8'h11, 8'h00, 16);
        spi_frame(8'hB0, 8'h00, 8'h00, 16);
        col_en = 1'b1;
        col_addr = 6'h31;
        col_data = 8'h42;
        spi_frame(8'h30, 8'h22, 8'h00, 16);
        spi_frame(8'hB0, 8'h00, 8'h00, 16);
        spi_frame(8'hB1, 8'h00, 8'h00, 16);
        // Multi-byte write with wrap (second byte lands only with burst support).
        spi_frame(8'h7F, 8'hAA, 8'hBB, 24);
        spi_frame(8'hBF, 8'h00, 8'h00, 16);
        spi_frame(8'h80, 8'h00, 8'h00, 16);

        // Randomized mix; mb is random since single-byte frames behave alike either way.
        for (int t = 0; t < 40; t++) begin
            op = int'($urandom_range(0, 2));
            a = 6'($urandom_range(0, 63));
            d = 8'($urandom_range(0, 255));
            mbr = 1'($urandom_range(0, 1));
            case (op)
                0: spi_frame({1'b1, mbr, a}, d, 8'h00, 16);
                1: spi_frame({1'b0, mbr, a}, d, 8'h00, 16);
                default: loc_write(a, d);
            endcase
        end

        // Final sweep of the whole register file.
        for (int i = 0; i < 64; i++) begin
            spi_frame({2'b10, 6'(i)}, 8'h00, 8'h00, 16);
        end

        repeat (20) @(negedge clk);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'h0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
